// File: rtl/ptx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptx_pkg
// Purpose  : Shared state encoding, line levels and counter sizing helper
//            for the parity frame transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package ptx_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_START  = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] S_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] S_STOP   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = S_IDLE,
        START  = S_START,
        DATA   = S_DATA,
        PARITY = S_PARITY,
        STOP   = S_STOP
    } ptx_state_t;

    // Line level while idle / during the start bit
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Counter width for a modulo-n counter; never narrower than one bit
    function automatic int ptx_cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : parity_tx_ctrl_if
// Purpose  : Word handshake and serial-line status bundle for the parity
//            frame transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface parity_tx_ctrl_if #(
    parameter int DATA_W = 4
) ();
    logic [DATA_W-1:0] in_seq;
    logic              in_valid;
    logic              in_ready;
    logic              serialOut;
    logic              parityBit;
    logic              busy;
    logic              done;

    // Word producer / link monitor side
    modport master (
        output in_seq,
        output in_valid,
        input  in_ready,
        input  serialOut,
        input  parityBit,
        input  busy,
        input  done
    );

    // Transmitter side
    modport slave (
        input  in_seq,
        input  in_valid,
        output in_ready,
        output serialOut,
        output parityBit,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/parity_tx_ctrl_gen.sv
`default_nettype none
// ============================================================================
// Module   : parity_gen
// Purpose  : Even-parity bit of a word (reduction XOR).
// Revision : 1.0 - initial release
// ============================================================================
module parity_gen #(
    parameter int DATA_W = 4
) (
    input  wire logic [DATA_W-1:0] i_data,
    output      logic              o_parity
);
    assign o_parity = ^i_data;
endmodule
`default_nettype wire

// File: rtl/parity_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parity_tx_ctrl
// Purpose  : Accepts a word over valid/ready and shifts out a serial frame:
//            start bit, data LSB-first, even-parity bit, stop bit. Each bit
//            is held BIT_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module parity_tx_ctrl
    import ptx_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int BIT_CYCLES = 1
) (
    input wire logic        clk,
    input wire logic        rst,
    parity_tx_ctrl_if.slave bus
);

    localparam int CYC_W = ptx_cnt_w(BIT_CYCLES);
    localparam int BIT_W = ptx_cnt_w(DATA_W);

    localparam logic [CYC_W-1:0] C_CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] C_CYC_ONE  = CYC_W'(1);
    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);

    ptx_state_t        r_state;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic              r_serial;
    logic [CYC_W-1:0]  r_cyc;
    logic [BIT_W-1:0]  r_bit;

    logic              w_parity;
    logic              w_slot_end;
    logic [DATA_W-1:0] w_shift_next;

    parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
        .i_data   (bus.in_seq),
        .o_parity (w_parity)
    );

    // Last clock of the current bit slot
    assign w_slot_end   = (r_cyc == C_CYC_LAST);
    assign w_shift_next = r_shift >> 1;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == STOP) && w_slot_end;
    assign bus.serialOut = r_serial;
    assign bus.parityBit = r_parity;

    // Frame sequencer; the serial line is registered and loaded with the
    // level of the slot being entered so it changes on the same edge as state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_serial <= IDLE_LEVEL;
            r_cyc    <= '0;
            r_bit    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_serial <= IDLE_LEVEL;
                    if (bus.in_valid) begin
                        r_shift  <= bus.in_seq;
                        r_parity <= w_parity;
                        r_serial <= START_LEVEL;
                        r_cyc    <= '0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_slot_end) begin
                        r_cyc    <= '0;
                        r_bit    <= '0;
                        r_serial <= r_shift[0];
                        r_state  <= DATA;
                    end else begin
                        r_cyc <= r_cyc + C_CYC_ONE;
                    end
                end
                DATA: begin
                    if (w_slot_end) begin
                        r_cyc   <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit == C_BIT_LAST) begin
                            r_bit    <= '0;
                            r_serial <= r_parity;
                            r_state  <= PARITY;
                        end else begin
                            r_bit    <= r_bit + C_BIT_ONE;
                            r_serial <= w_shift_next[0];
                        end
                    end else begin
                        r_cyc <= r_cyc + C_CYC_ONE;
                    end
                end
                PARITY: begin
                    if (w_slot_end) begin
                        r_cyc    <= '0;
                        r_serial <= IDLE_LEVEL;
                        r_state  <= STOP;
                    end else begin
                        r_cyc <= r_cyc + C_CYC_ONE;
                    end
                end
                STOP: begin
                    r_serial <= IDLE_LEVEL;
                    if (w_slot_end) begin
                        r_cyc   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cyc <= r_cyc + C_CYC_ONE;
                    end
                end
                default: begin
                    r_cyc    <= '0;
                    r_serial <= IDLE_LEVEL;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parity_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_tx_ctrl
// Purpose  : Self-checking bench for parity_tx_ctrl; two instances, one with
//            single-cycle bits and one holding each bit three cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_tx_ctrl;

    localparam int DW   = 4;
    localparam int BC_A = 1;
    localparam int BC_B = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   sel   = 0;

    logic obs_serial, obs_parity, obs_busy, obs_done, obs_ready;

    always #5 clk = ~clk;

    parity_tx_ctrl_if #(.DATA_W(DW)) ifa ();
    parity_tx_ctrl_if #(.DATA_W(DW)) ifb ();

    parity_tx_ctrl #(.DATA_W(DW), .BIT_CYCLES(BC_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    parity_tx_ctrl #(.DATA_W(DW), .BIT_CYCLES(BC_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    // Observe whichever instance the current step targets
    always_comb begin
        obs_serial = (sel == 0) ? ifa.serialOut : ifb.serialOut;
        obs_parity = (sel == 0) ? ifa.parityBit : ifb.parityBit;
        obs_busy   = (sel == 0) ? ifa.busy      : ifb.busy;
        obs_done   = (sel == 0) ? ifa.done      : ifb.done;
        obs_ready  = (sel == 0) ? ifa.in_ready  : ifb.in_ready;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut=%0d observed=%b expected=%b", tag, sel, obs, exp);
        end
    endtask

    // Reference line level at cycle c of a frame: slot 0 start, slots
    // 1..DW data LSB-first, then parity, then stop
    function automatic logic model_level(input logic [3:0] w, input int bc, input int c);
        int slot;
        slot = c / bc;
        if (slot == 0)       return 1'b0;
        else if (slot <= DW) return w[slot-1];
        else if (slot == DW + 1) return ^w;
        else                 return 1'b1;
    endfunction

    function automatic int bc_of(input int s);
        return (s == 0) ? BC_A : BC_B;
    endfunction

    task automatic drive(input logic v, input logic [3:0] w);
        if (sel == 0) begin
            ifa.in_valid = v;
            ifa.in_seq   = w;
        end else begin
            ifb.in_valid = v;
            ifb.in_seq   = w;
        end
    endtask

    // Check every cycle of a frame that was accepted at the previous edge;
    // optionally pulse in_valid with poke_w for one edge at cycle poke_c
    task automatic watch_frame(input logic [3:0] w, input int poke_c, input logic [3:0] poke_w);
        int bc;
        int len;
        bc  = bc_of(sel);
        len = (DW + 3) * bc;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            chk("serial", obs_serial, model_level(w, bc, c));
            chk("busy", obs_busy, 1'b1);
            chk("ready", obs_ready, 1'b0);
            chk("done", obs_done, c == len - 1);
            chk("parity", obs_parity, ^w);
            if (c == poke_c) drive(1'b1, poke_w);
            else if (c == poke_c + 1) drive(1'b0, poke_w);
        end
    endtask

    task automatic idle_check(input logic [3:0] last_w);
        @(negedge clk);
        chk("idle_serial", obs_serial, 1'b1);
        chk("idle_ready", obs_ready, 1'b1);
        chk("idle_busy", obs_busy, 1'b0);
        chk("idle_done", obs_done, 1'b0);
        chk("idle_parity", obs_parity, ^last_w);
    endtask

    task automatic send(input logic [3:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!obs_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", obs_ready, 1'b1);
        drive(1'b1, w);
        @(posedge clk);
        #1 drive(1'b0, w);
        watch_frame(w, -10, 4'h0);
        idle_check(w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rw;
        rst          = 1'b1;
        ifa.in_valid = 1'b0;
        ifa.in_seq   = 4'h0;
        ifb.in_valid = 1'b0;
        ifb.in_seq   = 4'h0;
        repeat (2) @(negedge clk);

        // Reset values on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_serial", obs_serial, 1'b1);
            chk("rst_parity", obs_parity, 1'b0);
            chk("rst_busy", obs_busy, 1'b0);
            chk("rst_done", obs_done, 1'b0);
            chk("rst_ready", obs_ready, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle bits: 4'h4 then 4'hF
        sel = 0;
        send(4'h4);
        send(4'hF);

        // Three-cycle bits: 4'hA, 21-cycle frame
        sel = 1;
        send(4'hA);

        // in_valid held high across two words: one idle cycle between frames
        sel = 0;
        @(negedge clk);
        drive(1'b1, 4'h1);
        @(posedge clk);
        #1 drive(1'b1, 4'h3);
        watch_frame(4'h1, -10, 4'h0);
        @(negedge clk);
        chk("gap_serial", obs_serial, 1'b1);
        chk("gap_ready", obs_ready, 1'b1);
        chk("gap_busy", obs_busy, 1'b0);
        chk("gap_parity", obs_parity, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 4'h3);
        watch_frame(4'h3, -10, 4'h0);
        idle_check(4'h3);

        // Word offered mid-frame is ignored
        @(negedge clk);
        drive(1'b1, 4'h2);
        @(posedge clk);
        #1 drive(1'b0, 4'h2);
        watch_frame(4'h2, 2, 4'h7);
        idle_check(4'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ign_done", obs_done, 1'b0);
            chk("ign_busy", obs_busy, 1'b0);
            chk("ign_serial", obs_serial, 1'b1);
        end

        // Reset in the parity slot of a 4'h7 frame
        @(negedge clk);
        drive(1'b1, 4'h7);
        @(posedge clk);
        #1 drive(1'b0, 4'h7);
        for (int c = 0; c <= DW + 1; c++) @(negedge clk);
        chk("pre_rst_line", obs_serial, 1'b1);
        chk("pre_rst_parity", obs_parity, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_serial", obs_serial, 1'b1);
        chk("arst_busy", obs_busy, 1'b0);
        chk("arst_parity", obs_parity, 1'b0);
        chk("arst_done", obs_done, 1'b0);
        chk("arst_ready", obs_ready, 1'b1);
        @(negedge clk);
        chk("arst_done2", obs_done, 1'b0);
        rst = 1'b0;
        send(4'h5);

        // Randomized words on both instances
        for (int i = 0; i < 16; i++) begin
            sel = i % 2;
            rw  = 4'($urandom_range(0, 15));
            send(rw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_tx_ctrl.md
# parity_tx_ctrl

Frame sequencer for the even-parity datapath. It accepts a data word over a valid/ready handshake and latches the word with its even-parity bit. It then shifts a serial frame out on a single line: start bit, data LSB-first, parity bit, stop bit. It sits between a word producer and a serial link, and is the block that sequences the parity generator.

## Interface
Parameters:
- DATA_W, 4, data word width in bits (≥1)
- BIT_CYCLES, 1, clock cycles each serial bit is held (≥1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- in_seq  input  DATA_W  data word to transmit
- in_valid  input  1  in_seq is valid
- in_ready  output  1  block can accept a word; high only in IDLE
- serialOut  output  1  serial line; idles high
- parityBit  output  1  even-parity bit of the word currently latched (XOR of all bits)
- busy  output  1  frame in progress (any state other than IDLE)
- done  output  1  one-cycle pulse when the stop bit completes

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: serialOut=1, in_ready=1. When in_valid&&in_ready at an edge:
  - latch in_seq into the shift register;
  - latch parityBit = ^in_seq;
  - go to START.
- START: serialOut=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA: serialOut = shift_reg[0]. Each bit is held BIT_CYCLES cycles, then the register shifts right. After DATA_W bits, go to PARITY.
- PARITY: serialOut=parityBit for BIT_CYCLES cycles, then go to STOP.
- STOP: serialOut=1 for BIT_CYCLES cycles. On the last cycle, done=1; the next state is IDLE.
- in_valid in any non-IDLE state is ignored. in_seq is not sampled and there is no back-pressure beyond in_ready=0.
- parityBit holds its value until the next accepted word.
- Counters:
  - cycle counter width max(1,$clog2(BIT_CYCLES)), wraps at BIT_CYCLES-1;
  - bit counter width max(1,$clog2(DATA_W)), wraps at DATA_W-1.
- Reset values: state=IDLE, serialOut=1, parityBit=0, busy=0, done=0, in_ready=1 (combinational from IDLE), shift register and counters 0.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously). The frame is discarded and done does not pulse.

## Timing
- in_ready, busy and done are decoded from state/counters. serialOut is registered.
- Acceptance at edge k:
  - serialOut=0 and busy=1 from k until k+BIT_CYCLES;
  - data bit i is on the line during [k+(1+i)·BIT_CYCLES, k+(2+i)·BIT_CYCLES).
- Frame length is (DATA_W+3)·BIT_CYCLES cycles. done is high in the final cycle of the frame.
- in_ready rises in the cycle after done.
- Back-to-back words therefore have exactly one idle-high cycle between frames; this is the minimum gap.
- Latency from acceptance to the first data bit is BIT_CYCLES cycles.

## Structure
- Shared package/header ptx_pkg:
  - state encoding localparams (3-bit: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - IDLE_LEVEL=1'b1, START_LEVEL=1'b0.
- Sub-module parity_gen, parameterised by DATA_W: a combinational reduction XOR, out = ^in. It is instantiated once and feeds the parityBit latch.
- The top level holds the FSM, the shift register and both counters.

## Test plan
- Reset, DATA_W=4, BIT_CYCLES=1, in_seq=4'h4 accepted → serialOut sequence 0,0,0,1,0,1,1; parityBit=1; done pulses in cycle 7; in_ready high in cycle 8.
- in_seq=4'hF → sequence 0,1,1,1,1,0,1; parityBit=0.
- BIT_CYCLES=3, in_seq=4'hA → each level held 3 cycles (0,0,1,0,1,0,1); 21-cycle frame; busy high for exactly 21 cycles.
- in_valid held high with 4'h1 then 4'h3 → two frames separated by exactly one idle-high cycle; parityBit 1 then 0.
- in_valid pulsed with 4'h7 during the DATA state of a 4'h2 frame → ignored; only the 4'h2 frame is transmitted; no second done.
- rst asserted in the PARITY state → serialOut=1, busy=0, parityBit=0 immediately; no done. After release, 4'h5 transmits a normal frame with parityBit=0.
